// File: rtl/ecg_pkg.sv
// ecg_pkg: shared state encoding and the fixed accelerator phase schedule
// used by the ECG stream feeder and its phase sequencer.
package ecg_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_STREAM,
    S_WAIT_DONE,
    S_RESULT,
    S_REARM
  } state_e;

  localparam int PHASE_LEN     = 22;
  localparam int NUM_PH        = 5;
  localparam int GAP_AFTER_P0  = 1;
  localparam int GAP_AFTER_P2  = 2;
  localparam int STREAM_CYCLES = 133;

  localparam int W_DEPTH = NUM_PH * PHASE_LEN;

  localparam int SAW = $clog2(PHASE_LEN);
  localparam int WAW = $clog2(W_DEPTH);
  localparam int IW  = $clog2(STREAM_CYCLES + 1);
  localparam int PW  = $clog2(NUM_PH + 1);

endpackage

// File: rtl/ecg_phase_sequencer.sv
// ecg_phase_sequencer: walks the accelerator phase schedule, giving RAM
// addresses, gap/phase flags and an end-of-schedule flag per stream cycle.
module ecg_phase_sequencer
  import ecg_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           en,
  output logic [WAW-1:0] waddr,
  output logic [SAW-1:0] saddr,
  output logic           gap,
  output logic           xin_phase,
  output logic           last
);

  logic [IW-1:0]  idx;
  logic [PW-1:0]  phase;
  logic [SAW-1:0] cnt;
  logic [1:0]     gcnt;

  // Advance one stream cycle; gaps follow P0 and P2, then the tail idles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx   <= '0;
      phase <= '0;
      cnt   <= '0;
      gcnt  <= '0;
    end else if (clr) begin
      idx   <= '0;
      phase <= '0;
      cnt   <= '0;
      gcnt  <= '0;
    end else if (en) begin
      idx <= idx + 1'b1;
      if (gcnt != 2'd0) begin
        gcnt <= gcnt - 1'b1;
      end else if (phase != PW'(NUM_PH)) begin
        if (cnt == SAW'(PHASE_LEN - 1)) begin
          cnt   <= '0;
          phase <= phase + 1'b1;
          gcnt  <= (phase == PW'(0)) ? 2'(GAP_AFTER_P0) :
                   (phase == PW'(2)) ? 2'(GAP_AFTER_P2) : 2'd0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign saddr     = cnt;
  assign waddr     = WAW'(phase) * WAW'(PHASE_LEN) + WAW'(cnt);
  assign gap       = (gcnt != 2'd0) || (phase == PW'(NUM_PH));
  assign xin_phase = (phase == PW'(0));
  assign last      = (idx == IW'(STREAM_CYCLES));

endmodule

// File: rtl/ecg_stream_feeder.sv
// ecg_stream_feeder: buffers a window plus weights, streams them into the
// ECG CNN accelerator and returns its detection. Option: ECG_FEEDER_TIMEOUT_EN.
module ecg_stream_feeder
  import ecg_pkg::*;
#(
  parameter int N          = 16,
  parameter int WINDOW_LEN = PHASE_LEN,
  parameter int NUM_PHASES = NUM_PH,
  parameter int TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic                ld_sel,
  input  logic signed [N-1:0] ld_data,
  input  logic                clear_buf,
  input  logic                run_req,
  output logic                busy,
  output logic                acc_start,
  output logic                acc_rst,
  output logic signed [N-1:0] acc_xin,
  output logic signed [N-1:0] acc_win,
  input  logic                acc_done,
  input  logic signed [N-1:0] acc_detection,
  output logic                res_valid,
  input  logic                res_ready,
  output logic signed [N-1:0] res_data,
  output logic                err
);

  localparam int WD  = NUM_PHASES * WINDOW_LEN;
  localparam int SCW = $clog2(WINDOW_LEN + 1);
  localparam int WCW = $clog2(WD + 1);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  state_e state;

  logic signed [N-1:0] smem [WINDOW_LEN];
  logic signed [N-1:0] wmem [WD];
  logic [SCW-1:0]      s_cnt;
  logic [WCW-1:0]      w_cnt;
  logic                s_full;
  logic                w_full;
  logic                wr;
  logic                accept;

  logic [WAW-1:0]      seq_waddr;
  logic [SAW-1:0]      seq_saddr;
  logic                seq_gap;
  logic                seq_xin;
  logic                seq_last;
  logic                seq_en;
  logic signed [N-1:0] nx_xin;
  logic signed [N-1:0] nx_win;

  assign s_full   = (s_cnt == SCW'(WINDOW_LEN));
  assign w_full   = (w_cnt == WCW'(WD));
  assign ld_ready = !rst && (state == S_IDLE) &&
                    !(ld_sel ? w_full : s_full);
  assign wr       = ld_valid && ld_ready && !clear_buf;
  assign accept   = (state == S_IDLE) && run_req && s_full && w_full;
  assign seq_en   = ((state == S_START) || (state == S_STREAM)) &&
                    !seq_last;

  ecg_phase_sequencer u_seq (
    .clk       (clk),
    .rst       (rst),
    .clr       (accept),
    .en        (seq_en),
    .waddr     (seq_waddr),
    .saddr     (seq_saddr),
    .gap       (seq_gap),
    .xin_phase (seq_xin),
    .last      (seq_last)
  );

  assign nx_win = seq_gap ? '0 : wmem[seq_waddr];
  assign nx_xin = (seq_gap || !seq_xin) ? '0 : smem[seq_saddr];

  // Buffer storage has no reset; contents are valid only up to fill counts.
  always_ff @(posedge clk) begin
    if (wr && !ld_sel) smem[s_cnt] <= ld_data;
    if (wr && ld_sel)  wmem[w_cnt] <= ld_data;
  end

  // Fill pointers; a clear in IDLE beats any same-cycle load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_cnt <= '0;
      w_cnt <= '0;
    end else if (clear_buf && (state == S_IDLE)) begin
      s_cnt <= '0;
      w_cnt <= '0;
    end else if (wr) begin
      if (ld_sel) w_cnt <= w_cnt + 1'b1;
      else        s_cnt <= s_cnt + 1'b1;
    end
  end

`ifdef ECG_FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;
`else
  assign err = 1'b0;
`endif

  // Run sequencer with all accelerator-facing outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      acc_start <= 1'b0;
      acc_rst   <= 1'b0;
      acc_xin   <= '0;
      acc_win   <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
`ifdef ECG_FEEDER_TIMEOUT_EN
      err       <= 1'b0;
      tcnt      <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state     <= S_START;
            acc_start <= 1'b1;
            busy      <= 1'b1;
`ifdef ECG_FEEDER_TIMEOUT_EN
            err       <= 1'b0;
`endif
          end
        end
        S_START: begin
          acc_start <= 1'b0;
          acc_xin   <= nx_xin;
          acc_win   <= nx_win;
          state     <= S_STREAM;
        end
        S_STREAM: begin
          if (seq_last) begin
            acc_xin <= '0;
            acc_win <= '0;
            state   <= S_WAIT_DONE;
`ifdef ECG_FEEDER_TIMEOUT_EN
            tcnt    <= '0;
`endif
          end else begin
            acc_xin <= nx_xin;
            acc_win <= nx_win;
          end
        end
        S_WAIT_DONE: begin
          if (acc_done) begin
            res_data  <= acc_detection;
            res_valid <= 1'b1;
            state     <= S_RESULT;
          end
`ifdef ECG_FEEDER_TIMEOUT_EN
          else if (tcnt == TW'(TIMEOUT - 1)) begin
            err       <= 1'b1;
            res_data  <= '0;
            res_valid <= 1'b1;
            state     <= S_RESULT;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
`endif
        end
        S_RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            acc_rst   <= 1'b1;
            state     <= S_REARM;
          end
        end
        S_REARM: begin
          acc_rst <= 1'b0;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ecg_stream_feeder.sv
// tb_ecg_stream_feeder: directed vectors for load, stream schedule,
// result handshake, re-arm, reset and the optional done timeout.
module tb_ecg_stream_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_valid;
  logic        ld_ready;
  logic        ld_sel;
  logic [15:0] ld_data;
  logic        clear_buf;
  logic        run_req;
  logic        busy;
  logic        acc_start;
  logic        acc_rst;
  logic [15:0] acc_xin;
  logic [15:0] acc_win;
  logic        acc_done;
  logic [15:0] acc_detection;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          cyc;
    logic [15:0] xin;
    logic [15:0] win;
  } vec_t;

  localparam int NV = 12;
  vec_t tab [NV];

  ecg_stream_feeder dut (
    .clk           (clk),
    .rst           (rst),
    .ld_valid      (ld_valid),
    .ld_ready      (ld_ready),
    .ld_sel        (ld_sel),
    .ld_data       (ld_data),
    .clear_buf     (clear_buf),
    .run_req       (run_req),
    .busy          (busy),
    .acc_start     (acc_start),
    .acc_rst       (acc_rst),
    .acc_xin       (acc_xin),
    .acc_win       (acc_win),
    .acc_done      (acc_done),
    .acc_detection (acc_detection),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_data      (res_data),
    .err           (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_win(input int c, input int wb);
    int st [5] = '{0, 23, 45, 69, 91};
    for (int p = 0; p < 5; p++)
      if (c >= st[p] && c < st[p] + 22)
        return 16'(wb + p * 22 + c - st[p]);
    return 16'h0;
  endfunction

  function automatic logic [15:0] exp_xin(input int c, input int sb);
    return (c < 22) ? 16'(sb + c) : 16'h0;
  endfunction

  task automatic load(input logic sel, input int d);
    ld_sel   = sel;
    ld_data  = 16'(d);
    ld_valid = 1'b1;
    #1;
    chk("ld_ready_load", {31'd0, ld_ready}, 32'd1);
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
  endtask

  // Called in the START cycle; returns positioned on stream cycle ncyc-1.
  task automatic do_stream(input int sb, input int wb, input int ncyc,
                           input bit use_tab, input int spur);
    tick();
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) tick();
      if (c == spur) begin
        acc_done      = 1'b1;
        acc_detection = 16'hdead;
      end
      if (c == spur + 1) acc_done = 1'b0;
      chk($sformatf("stream_xin c%0d", c), {16'd0, acc_xin},
          {16'd0, exp_xin(c, sb)});
      chk($sformatf("stream_win c%0d", c), {16'd0, acc_win},
          {16'd0, exp_win(c, wb)});
      if (use_tab)
        for (int t = 0; t < NV; t++)
          if (tab[t].cyc == c) begin
            chk($sformatf("tab_xin c%0d", c), {16'd0, acc_xin},
                {16'd0, tab[t].xin});
            chk($sformatf("tab_win c%0d", c), {16'd0, acc_win},
                {16'd0, tab[t].win});
          end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end

  initial begin
    tab[0]  = '{0,   16'd1,  16'd100};
    tab[1]  = '{21,  16'd22, 16'd121};
    tab[2]  = '{22,  16'd0,  16'd0};
    tab[3]  = '{23,  16'd0,  16'd122};
    tab[4]  = '{44,  16'd0,  16'd143};
    tab[5]  = '{45,  16'd0,  16'd144};
    tab[6]  = '{67,  16'd0,  16'd0};
    tab[7]  = '{68,  16'd0,  16'd0};
    tab[8]  = '{69,  16'd0,  16'd166};
    tab[9]  = '{112, 16'd0,  16'd209};
    tab[10] = '{113, 16'd0,  16'd0};
    tab[11] = '{132, 16'd0,  16'd0};

    rst = 1'b1;
    ld_valid = 0; ld_sel = 0; ld_data = 0; clear_buf = 0;
    run_req = 0; acc_done = 0; acc_detection = 0; res_ready = 0;
    tick(); tick();
    chk("rst_ld_ready", {31'd0, ld_ready}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_acc_start", {31'd0, acc_start}, 0);
    chk("rst_acc_rst", {31'd0, acc_rst}, 0);
    chk("rst_xin", {16'd0, acc_xin}, 0);
    chk("rst_win", {16'd0, acc_win}, 0);
    chk("rst_res_valid", {31'd0, res_valid}, 0);
    chk("rst_res_data", {16'd0, res_data}, 0);
    chk("rst_err", {31'd0, err}, 0);
    rst = 1'b0;
    tick();
    chk("idle_ld_ready", {31'd0, ld_ready}, 1);

    for (int i = 0; i < 21; i++) load(1'b0, i + 1);
    for (int i = 0; i < 110; i++) load(1'b1, 100 + i);

    run_req = 1'b1; tick(); run_req = 1'b0;
    chk("short_run_start", {31'd0, acc_start}, 0);
    chk("short_run_busy", {31'd0, busy}, 0);
    tick();
    chk("short_run_busy2", {31'd0, busy}, 0);

    ld_sel = 1'b1; ld_valid = 1'b1; #1;
    chk("ld_ready_wfull", {31'd0, ld_ready}, 0);
    ld_valid = 1'b0;
    load(1'b0, 22);
    ld_sel = 1'b0; #1;
    chk("ld_ready_sfull", {31'd0, ld_ready}, 0);

    run_req = 1'b1; tick(); run_req = 1'b0;
    chk("run1_start", {31'd0, acc_start}, 1);
    chk("run1_busy", {31'd0, busy}, 1);
    ld_valid = 1'b1; #1;
    chk("ld_ready_busy", {31'd0, ld_ready}, 0);
    ld_valid = 1'b0;

    do_stream(1, 100, 133, 1'b1, 10);
    tick();
    chk("wait_xin", {16'd0, acc_xin}, 0);
    chk("wait_win", {16'd0, acc_win}, 0);
    chk("spur_done_ignored", {31'd0, res_valid}, 0);
    tick(); tick(); tick();
    chk("wait_no_result", {31'd0, res_valid}, 0);
    acc_done = 1'b1; acc_detection = 16'h0123;
    tick();
    acc_done = 1'b0; acc_detection = 16'h0;
    chk("res_valid", {31'd0, res_valid}, 1);
    chk("res_data", {16'd0, res_data}, 32'h0123);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("res_hold_valid %0d", k), {31'd0, res_valid}, 1);
      chk($sformatf("res_hold_data %0d", k), {16'd0, res_data},
          32'h0123);
    end
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    chk("rearm_acc_rst", {31'd0, acc_rst}, 1);
    chk("rearm_busy", {31'd0, busy}, 1);
    chk("rearm_res_valid", {31'd0, res_valid}, 0);
    tick();
    chk("idle_acc_rst", {31'd0, acc_rst}, 0);
    chk("idle_busy", {31'd0, busy}, 0);

    run_req = 1'b1; tick(); run_req = 1'b0;
    chk("rerun_start", {31'd0, acc_start}, 1);
    do_stream(1, 100, 51, 1'b0, -1);
    rst = 1'b1; #1;
    chk("mid_rst_xin", {16'd0, acc_xin}, 0);
    chk("mid_rst_win", {16'd0, acc_win}, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_acc_rst", {31'd0, acc_rst}, 0);
    chk("mid_rst_ld_ready", {31'd0, ld_ready}, 0);
    tick();
    rst = 1'b0;
    tick();
    ld_sel = 1'b0; #1;
    chk("post_rst_ld_ready", {31'd0, ld_ready}, 1);
    run_req = 1'b1; tick(); run_req = 1'b0;
    chk("post_rst_no_start", {31'd0, acc_start}, 0);
    chk("post_rst_no_busy", {31'd0, busy}, 0);

    load(1'b0, 7); load(1'b0, 8); load(1'b1, 1); load(1'b1, 2);
    clear_buf = 1'b1; ld_valid = 1'b1; ld_sel = 1'b0; ld_data = 16'h55;
    tick();
    clear_buf = 1'b0; ld_valid = 1'b0;
    for (int i = 0; i < 22; i++) load(1'b0, 31 + i);
    ld_sel = 1'b0; #1;
    chk("sfull_after_clear", {31'd0, ld_ready}, 0);
    for (int i = 0; i < 110; i++) load(1'b1, 300 + i);

    run_req = 1'b1; tick(); run_req = 1'b0;
    chk("run2_start", {31'd0, acc_start}, 1);
    do_stream(31, 300, 133, 1'b0, -1);
    acc_done = 1'b1; acc_detection = 16'hbeef;
    tick();
    chk("early_done_wait0", {31'd0, res_valid}, 0);
    tick();
    acc_done = 1'b0; acc_detection = 16'h0;
    chk("early_done_valid", {31'd0, res_valid}, 1);
    chk("early_done_data", {16'd0, res_data}, 32'hbeef);
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    tick();
    chk("run2_idle_busy", {31'd0, busy}, 0);

`ifdef ECG_FEEDER_TIMEOUT_EN
    run_req = 1'b1; tick(); run_req = 1'b0;
    chk("to_start", {31'd0, acc_start}, 1);
    do_stream(31, 300, 133, 1'b0, -1);
    tick();
    for (int k = 1; k < 255; k++) tick();
    chk("to_not_yet_valid", {31'd0, res_valid}, 0);
    chk("to_not_yet_err", {31'd0, err}, 0);
    tick();
    chk("to_err", {31'd0, err}, 1);
    chk("to_valid", {31'd0, res_valid}, 1);
    chk("to_data", {16'd0, res_data}, 0);
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    chk("to_rearm", {31'd0, acc_rst}, 1);
    tick();
    chk("to_err_sticky", {31'd0, err}, 1);
    run_req = 1'b1; tick(); run_req = 1'b0;
    chk("to_err_cleared", {31'd0, err}, 0);
    chk("to_rerun_start", {31'd0, acc_start}, 1);
`else
    chk("err_tied_low", {31'd0, err}, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
